// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single ZBT memory_interface port between three
// pixel clients (0 = vga read-out, 1 = ntsc capture writer, 2 = lpf).
// Each client holds flag/wr/x/y/wdata stable until it receives a one-cycle done.
// Client 0 has fixed priority, clients 1/2 alternate round-robin, and a client
// 1/2 that has waited MAX_WAIT cycles overrides everyone. One transaction is in
// flight at a time; a watchdog aborts it if memory never answers.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   req_flag/wr[2:0]      per-client request and write enable
//   req_x/y/wdata         packed per-client fields, client i at [i*W +: W]
//   done[2:0]             one-cycle completion pulse to the granted client
//   rdata                 read data, valid while done is high (0 on abort)
//   grant[2:0]            one-hot owner of the port, 0 when idle
//   timeout_err           one-cycle pulse on watchdog abort
//   mem_flag/wr/x/y/wdata request towards memory_interface
//   mem_done, mem_rdata   completion pulse and read data from memory_interface
module mem_port_arbiter #(
  parameter int unsigned W_X      = 10,
  parameter int unsigned W_Y      = 9,
  parameter int unsigned W_D      = 36,
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       req_flag,
  input  logic [2:0]       req_wr,
  input  logic [3*W_X-1:0] req_x,
  input  logic [3*W_Y-1:0] req_y,
  input  logic [3*W_D-1:0] req_wdata,
  output logic [2:0]       done,
  output logic [W_D-1:0]   rdata,
  output logic [2:0]       grant,
  output logic             timeout_err,
  output logic             mem_flag,
  output logic             mem_wr,
  output logic [W_X-1:0]   mem_x,
  output logic [W_Y-1:0]   mem_y,
  output logic [W_D-1:0]   mem_wdata,
  input  logic             mem_done,
  input  logic [W_D-1:0]   mem_rdata
);

  localparam int unsigned W_AGE = 8;
  localparam int unsigned W_WD  = 8;
  localparam logic [W_AGE-1:0] AGE_MAX = W_AGE'(MAX_WAIT);
  localparam logic [W_WD-1:0]  WD_MAX  = W_WD'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

  state_t           state, state_nxt;
  logic [1:0]       rr_last, rr_last_nxt;
  logic [W_AGE-1:0] age_1, age_1_nxt, age_2, age_2_nxt;
  logic [W_WD-1:0]  wd, wd_nxt, wd_inc;

  logic [2:0]       done_nxt, grant_nxt;
  logic [W_D-1:0]   rdata_nxt, mem_wdata_nxt;
  logic             timeout_err_nxt, mem_flag_nxt, mem_wr_nxt;
  logic [W_X-1:0]   mem_x_nxt;
  logic [W_Y-1:0]   mem_y_nxt;

  logic [1:0]       win, rr_pick;
  logic             old_1, old_2, take;
  logic             win_wr;
  logic [W_X-1:0]   win_x;
  logic [W_Y-1:0]   win_y;
  logic [W_D-1:0]   win_d;

  // Winner selection: aged client 1/2 first, then client 0, then round-robin.
  // Age is gated by the live flag so a client that just dropped cannot win.
  always_comb begin
    rr_pick = (rr_last == 2'd1) ? 2'd2 : 2'd1;
    old_1   = req_flag[1] && (age_1 == AGE_MAX);
    old_2   = req_flag[2] && (age_2 == AGE_MAX);
    win     = 2'd0;
    if (old_1 && old_2)                  win = rr_pick;
    else if (old_1)                      win = 2'd1;
    else if (old_2)                      win = 2'd2;
    else if (req_flag[0])                win = 2'd0;
    else if (req_flag[1] && req_flag[2]) win = rr_pick;
    else if (req_flag[1])                win = 2'd1;
    else if (req_flag[2])                win = 2'd2;
  end

  assign take = (state == IDLE) && (|req_flag);

  // Only the winner's fields ever reach the memory side.
  always_comb begin
    win_wr = req_wr[0];
    win_x  = req_x[0 +: W_X];
    win_y  = req_y[0 +: W_Y];
    win_d  = req_wdata[0 +: W_D];
    case (win)
      2'd1: begin
        win_wr = req_wr[1];
        win_x  = req_x[W_X +: W_X];
        win_y  = req_y[W_Y +: W_Y];
        win_d  = req_wdata[W_D +: W_D];
      end
      2'd2: begin
        win_wr = req_wr[2];
        win_x  = req_x[2*W_X +: W_X];
        win_y  = req_y[2*W_Y +: W_Y];
        win_d  = req_wdata[2*W_D +: W_D];
      end
      default: ;
    endcase
  end

  // Aging: counts refused cycles, cleared by ownership, a fresh grant or a dropped flag.
  always_comb begin
    age_1_nxt = age_1;
    age_2_nxt = age_2;
    if (!req_flag[1] || grant[1] || (take && win == 2'd1)) age_1_nxt = '0;
    else if (age_1 < AGE_MAX)                              age_1_nxt = age_1 + W_AGE'(1);
    if (!req_flag[2] || grant[2] || (take && win == 2'd2)) age_2_nxt = '0;
    else if (age_2 < AGE_MAX)                              age_2_nxt = age_2 + W_AGE'(1);
  end

  // Next state and registered outputs.
  always_comb begin
    state_nxt       = state;
    rr_last_nxt     = rr_last;
    wd_nxt          = wd;
    wd_inc          = wd + W_WD'(1);
    done_nxt        = '0;
    timeout_err_nxt = 1'b0;
    rdata_nxt       = rdata;
    grant_nxt       = grant;
    mem_flag_nxt    = mem_flag;
    mem_wr_nxt      = mem_wr;
    mem_x_nxt       = mem_x;
    mem_y_nxt       = mem_y;
    mem_wdata_nxt   = mem_wdata;
    case (state)
      IDLE: begin
        if (take) begin
          state_nxt     = BUSY;
          wd_nxt        = '0;
          mem_flag_nxt  = 1'b1;
          grant_nxt     = 3'b001 << win;
          mem_wr_nxt    = win_wr;
          mem_x_nxt     = win_x;
          mem_y_nxt     = win_y;
          mem_wdata_nxt = win_d;
          if (win != 2'd0) rr_last_nxt = win;
        end
      end
      BUSY: begin
        // mem_done has precedence over an abort in the same cycle.
        if (mem_done) begin
          state_nxt    = RESPOND;
          rdata_nxt    = mem_rdata;
          done_nxt     = grant;
          mem_flag_nxt = 1'b0;
        end else if (wd_inc == WD_MAX) begin
          state_nxt       = RESPOND;
          wd_nxt          = wd_inc;
          rdata_nxt       = '0;
          done_nxt        = grant;
          timeout_err_nxt = 1'b1;
          mem_flag_nxt    = 1'b0;
        end else begin
          wd_nxt = wd_inc;
        end
      end
      RESPOND: begin
        // Flags are not sampled here, letting the client drop or replace its request.
        state_nxt = IDLE;
        grant_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rr_last     <= '0;
      age_1       <= '0;
      age_2       <= '0;
      wd          <= '0;
      done        <= '0;
      rdata       <= '0;
      grant       <= '0;
      timeout_err <= 1'b0;
      mem_flag    <= 1'b0;
      mem_wr      <= 1'b0;
      mem_x       <= '0;
      mem_y       <= '0;
      mem_wdata   <= '0;
    end else begin
      state       <= state_nxt;
      rr_last     <= rr_last_nxt;
      age_1       <= age_1_nxt;
      age_2       <= age_2_nxt;
      wd          <= wd_nxt;
      done        <= done_nxt;
      rdata       <= rdata_nxt;
      grant       <= grant_nxt;
      timeout_err <= timeout_err_nxt;
      mem_flag    <= mem_flag_nxt;
      mem_wr      <= mem_wr_nxt;
      mem_x       <= mem_x_nxt;
      mem_y       <= mem_y_nxt;
      mem_wdata   <= mem_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned W_X      = 10;
  localparam int unsigned W_Y      = 9;
  localparam int unsigned W_D      = 36;
  localparam int unsigned MAX_WAIT = 64;
  localparam int unsigned TIMEOUT  = 255;

  logic             clock = 1'b0;
  logic             reset;
  logic [2:0]       req_flag, req_wr;
  logic [3*W_X-1:0] req_x;
  logic [3*W_Y-1:0] req_y;
  logic [3*W_D-1:0] req_wdata;
  logic [2:0]       done, grant;
  logic [W_D-1:0]   rdata, mem_wdata, mem_rdata;
  logic             timeout_err, mem_flag, mem_wr, mem_done;
  logic [W_X-1:0]   mem_x;
  logic [W_Y-1:0]   mem_y;

  logic [W_X-1:0] c_x [3];
  logic [W_Y-1:0] c_y [3];
  logic [W_D-1:0] c_d [3];

  assign req_x     = {c_x[2], c_x[1], c_x[0]};
  assign req_y     = {c_y[2], c_y[1], c_y[0]};
  assign req_wdata = {c_d[2], c_d[1], c_d[0]};

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .W_X(W_X), .W_Y(W_Y), .W_D(W_D), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .req_flag(req_flag), .req_wr(req_wr), .req_x(req_x), .req_y(req_y), .req_wdata(req_wdata),
    .done(done), .rdata(rdata), .grant(grant), .timeout_err(timeout_err),
    .mem_flag(mem_flag), .mem_wr(mem_wr), .mem_x(mem_x), .mem_y(mem_y), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, identified by its owner.
  int             m_owner;      // -1 when the port is free
  bit             m_fin;        // transaction finished, done showing this cycle
  int             m_wait;       // busy cycles without an answer
  int             m_rr;
  int             m_age [3];
  logic [2:0]     e_done, e_grant;
  logic [W_D-1:0] e_rdata, e_md;
  logic           e_terr, e_mflag, e_mwr;
  logic [W_X-1:0] e_mx;
  logic [W_Y-1:0] e_my;

  // Stimulus knobs and memory responder state.
  int p_req [3];
  int p_again [3];
  int lat_q [$];
  int lat;
  int m_cnt;

  task automatic model_reset();
    m_owner = -1; m_fin = 0; m_wait = 0; m_rr = 0;
    for (int i = 0; i < 3; i++) m_age[i] = 0;
    e_done = '0; e_grant = '0; e_rdata = '0; e_md = '0;
    e_terr = 0; e_mflag = 0; e_mwr = 0; e_mx = '0; e_my = '0;
  endtask

  function automatic int pick_winner();
    bit old1, old2;
    int first;
    old1  = req_flag[1] && (m_age[1] == MAX_WAIT);
    old2  = req_flag[2] && (m_age[2] == MAX_WAIT);
    first = (m_rr == 1) ? 2 : 1;
    if (old1 && old2) return first;
    if (old1) return 1;
    if (old2) return 2;
    if (req_flag[0]) return 0;
    if (req_flag[1] && req_flag[2]) return first;
    if (req_flag[1]) return 1;
    return 2;
  endfunction

  task automatic model_step();
    int w;
    int na [3];
    if (reset) begin
      model_reset();
      return;
    end
    w = -1;
    if (m_owner < 0 && req_flag != 3'b000) w = pick_winner();
    for (int i = 1; i < 3; i++) begin
      if (!req_flag[i] || m_owner == i || w == i) na[i] = 0;
      else na[i] = (m_age[i] + 1 > int'(MAX_WAIT)) ? int'(MAX_WAIT) : m_age[i] + 1;
    end
    e_done = '0;
    e_terr = 1'b0;
    if (m_owner >= 0 && m_fin) begin
      e_grant = '0;
      m_owner = -1;
      m_fin   = 0;
    end else if (m_owner >= 0) begin
      if (mem_done) begin
        e_rdata = mem_rdata;
        e_done  = 3'(1 << m_owner);
        e_mflag = 1'b0;
        m_fin   = 1;
      end else begin
        m_wait++;
        if (m_wait == int'(TIMEOUT)) begin
          e_rdata = '0;
          e_done  = 3'(1 << m_owner);
          e_terr  = 1'b1;
          e_mflag = 1'b0;
          m_fin   = 1;
        end
      end
    end else if (w >= 0) begin
      m_owner = w;
      m_wait  = 0;
      e_mflag = 1'b1;
      e_grant = 3'(1 << w);
      e_mwr   = req_wr[w];
      e_mx    = c_x[w];
      e_my    = c_y[w];
      e_md    = c_d[w];
      if (w > 0) m_rr = w;
    end
    m_age[1] = na[1];
    m_age[2] = na[2];
  endtask

  task automatic compare_outputs();
    check("done", 64'(done), 64'(e_done));
    check("grant", 64'(grant), 64'(e_grant));
    check("timeout_err", 64'(timeout_err), 64'(e_terr));
    check("mem_flag", 64'(mem_flag), 64'(e_mflag));
    if (e_mflag) begin
      check("mem_wr", 64'(mem_wr), 64'(e_mwr));
      check("mem_x", 64'(mem_x), 64'(e_mx));
      check("mem_y", 64'(mem_y), 64'(e_my));
      check("mem_wdata", 64'(mem_wdata), 64'(e_md));
    end
    if (e_done != 3'b000) check("rdata", 64'(rdata), 64'(e_rdata));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_rdata"}, 64'(rdata), 64'd0);
    check({tag, "_grant"}, 64'(grant), 64'd0);
    check({tag, "_terr"}, 64'(timeout_err), 64'd0);
    check({tag, "_mem_flag"}, 64'(mem_flag), 64'd0);
    check({tag, "_mem_wr"}, 64'(mem_wr), 64'd0);
    check({tag, "_mem_x"}, 64'(mem_x), 64'd0);
    check({tag, "_mem_y"}, 64'(mem_y), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  task automatic new_req(input int i);
    req_flag[i] = 1'b1;
    req_wr[i]   = 1'($urandom);
    c_x[i]      = W_X'($urandom);
    c_y[i]      = W_Y'($urandom);
    c_d[i]      = W_D'({$urandom, $urandom});
  endtask

  // Clients follow the handshake: hold until done, then drop or replace.
  task automatic drive_clients();
    for (int i = 0; i < 3; i++) begin
      if (e_done[i]) begin
        req_flag[i] = 1'b0;
        if (int'($urandom_range(99)) < p_again[i]) new_req(i);
      end else if (!req_flag[i] && int'($urandom_range(99)) < p_req[i]) begin
        new_req(i);
      end
    end
  endtask

  function automatic int next_lat();
    if (lat_q.size() != 0) return lat_q.pop_front();
    if ($urandom_range(99) < 2) return -1;
    return int'($urandom_range(5));
  endfunction

  // Memory answers after a per-transaction latency (-1 = never); stray pulses while idle.
  task automatic drive_mem();
    mem_rdata = W_D'({$urandom, $urandom});
    if (e_mflag) begin
      if (m_cnt == 0) lat = next_lat();
      mem_done = (m_cnt == lat);
      m_cnt++;
    end else begin
      m_cnt    = 0;
      mem_done = ($urandom_range(9) == 0);
    end
  endtask

  task automatic run_cycle();
    @(negedge clock);
    compare_outputs();
    drive_clients();
    drive_mem();
    model_step();
  endtask

  task automatic set_knobs(input int r0, r1, r2, a0, a1, a2);
    p_req[0] = r0; p_req[1] = r1; p_req[2] = r2;
    p_again[0] = a0; p_again[1] = a1; p_again[2] = a2;
  endtask

  initial begin
    reset = 1'b1; req_flag = '0; req_wr = '0; mem_done = 1'b0; mem_rdata = '0;
    m_cnt = 0; lat = 0;
    for (int i = 0; i < 3; i++) begin c_x[i] = '0; c_y[i] = '0; c_d[i] = '0; end
    set_knobs(0, 0, 0, 0, 0, 0);
    model_reset();

    // Reset state
    run_cycle();
    run_cycle();
    check_all_zero("reset");
    reset = 1'b0;

    // Mixed random traffic
    set_knobs(30, 30, 30, 20, 20, 20);
    repeat (2000) run_cycle();

    // Saturated: client 0 always present, aging must let 1 and 2 through
    set_knobs(100, 100, 100, 100, 100, 100);
    repeat (1500) run_cycle();

    // Clients 1 and 2 only: round-robin
    set_knobs(0, 100, 100, 0, 100, 100);
    repeat (300) run_cycle();

    // Watchdog boundaries: never answer, answer on the last cycle, one before, immediate
    lat_q = '{-1, 254, 253, 0, 1, -1};
    set_knobs(0, 0, 100, 0, 0, 100);
    repeat (1200) run_cycle();

    // Reset mid-transaction, then a stray mem_done
    set_knobs(0, 0, 0, 0, 0, 0);
    repeat (300) begin
      if (!e_mflag) run_cycle();
    end
    if (!e_mflag) begin
      set_knobs(0, 0, 100, 0, 0, 100);
      for (int k = 0; k < 300 && !e_mflag; k++) run_cycle();
      check("busy_reached", 64'(e_mflag), 64'd1);
    end
    @(negedge clock);
    compare_outputs();
    set_knobs(0, 0, 0, 0, 0, 0);
    reset = 1'b1; req_flag = '0; mem_done = 1'b0;
    model_step();
    @(negedge clock);
    compare_outputs();
    check_all_zero("midreset");
    reset = 1'b0; mem_done = 1'b0; m_cnt = 0;
    model_step();
    @(negedge clock);
    compare_outputs();
    mem_done = 1'b1;
    model_step();
    repeat (3) begin
      @(negedge clock);
      compare_outputs();
      mem_done = 1'b0;
      model_step();
    end
    check_all_zero("stray_done");

    // Service resumes normally after reset
    set_knobs(40, 40, 40, 30, 30, 30);
    repeat (400) run_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
